// File: rtl/sub_serial8.sv
// Multi-cycle subtractor: computes a - b - bin one 8-bit slice per clock, LSB slice first,
// with a registered borrow between slices and a valid/ready handshake on both sides.
module sub_serial8 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned SLICES = WIDTH / 8;
    localparam int unsigned CntW   = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              borrow_q, borrow_d;
    logic              nz_q, nz_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic [7:0]        a8, b8, d8;
    logic [8:0]        sum9;
    logic              borrow_nxt;
    logic              last;
    logic [WIDTH+7:0]  diff_sh;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        nz_d     = nz_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        // a - b - br == a + ~b + ~br; carry-out of that sum is the inverted borrow
        a8         = a_q[7:0];
        b8         = b_q[7:0];
        sum9       = {1'b0, a8} + {1'b0, ~b8} + {8'd0, ~borrow_q};
        d8         = sum9[7:0];
        borrow_nxt = ~sum9[8];
        last       = (cnt_q == CntW'(SLICES - 1));
        diff_sh    = {d8, diff_q};

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    nz_d     = 1'b0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d      = a_q >> 8;
                b_d      = b_q >> 8;
                borrow_d = borrow_nxt;
                diff_d   = diff_sh[WIDTH+7:8];
                nz_d     = nz_q | (|d8);
                if (last) begin
                    bout_d  = borrow_nxt;
                    zero_d  = ~(nz_q | (|d8));
                    ovf_d   = (a_msb_q ^ b_msb_q) & (d8[7] ^ a_msb_q);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            nz_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            nz_q     <= nz_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/sub_serial8.md
# sub_serial8

Multi-cycle unsigned/two's-complement subtractor for wide operands. It computes A − B − borrow-in one 8-bit slice per clock, least-significant slice first, and registers the borrow between slices. It is the subtract-direction counterpart to the team's 8-bit carry-lookahead adder slice. It sits between a valid/ready producer and consumer on datapaths where a full-width single-cycle borrow chain would not close timing.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be a multiple of 8 and at least 8.
- `SLICES`, derived as `WIDTH/8`, not overridable: number of 8-bit slices processed.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block can accept operands. High only in IDLE.
- `a`  in  WIDTH: minuend.
- `b`  in  WIDTH: subtrahend.
- `bin`  in  1: borrow-in.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `diff`  out  WIDTH: (a − b − bin) mod 2^WIDTH.
- `bout`  out  1: unsigned borrow-out. 1 iff a < b + bin.
- `zero`  out  1: diff == 0.
- `ovf`  out  1: signed overflow. a[MSB] ≠ b[MSB] and diff[MSB] ≠ a[MSB].

## Operation
- **FSM states:** IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a`, `b` and `bin` into operand shift registers, clear the slice counter, and go to RUN.
  - `in_valid` without a handshake has no effect.
- **RUN:** each cycle processes slice k = counter.
  - {borrow_next, d8} = a[8k+7:8k] − b[8k+7:8k] − borrow. The borrow register starts at the latched `bin`.
  - The arithmetic may be implemented as a + ~b + ~borrow, with carry-out inverted to give borrow_next.
  - d8 shifts into the top of the `diff` register, which is a right-shifting accumulator. Operand registers shift right by 8.
  - When counter == SLICES−1: register `bout` = borrow_next, `zero`, and `ovf`, using the MSB of the original `a` and `b` held in dedicated bits. Then go to DONE.
  - The counter is clog2(SLICES) bits, minimum 1. It does not wrap during a normal operation.
- **DONE:**
  - `out_valid`=1; `diff`, `bout`, `zero` and `ovf` are held stable.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 throughout, so results never overlap.
- **Output registers:** `diff`, `bout`, `zero` and `ovf` are meaningful only while `out_valid`=1. Outside DONE they may show partial values but never glitch within a cycle, since all are registered.
- **Reset:**
  - Reset values: `out_valid`=0, `diff`=0, `bout`=0, `zero`=0, `ovf`=0. `in_ready` reads 1 from the first cycle after `rst` deasserts.
  - `rst` asserted in any state, including mid-RUN or DONE, aborts the operation. No `out_valid` is produced for it.
  - `rst` overrides any handshake in the same cycle.
- **WIDTH=8:** RUN lasts exactly one cycle.

## Timing
- **Input handshake:** at rising edge T with `in_valid`&&`in_ready`.
- **RUN:** occupies edges T+1 … T+SLICES.
- **Output:** `out_valid` rises after edge T+SLICES. Latency is SLICES cycles from accept to `out_valid`.
- **Output handshake:** at the first edge where `out_valid`&&`out_ready`. `in_ready` is high the following cycle.
- **Throughput:** at most one operation per SLICES+2 cycles, with `out_ready` tied high.
- **Critical path:** one 8-bit subtract plus borrow register. There is no full-width combinational path other than the `zero` reduction, which is computed incrementally as a per-slice OR accumulated in RUN.

## Test plan
- **Borrow across a slice boundary (WIDTH=32):** a=0x00000100, b=0x00000001, bin=0 → diff=0x000000FF, bout=0, zero=0, ovf=0. `out_valid` arrives exactly 4 cycles after accept.
- **Unsigned underflow:** a=0x00000000, b=0x00000001, bin=0 → diff=0xFFFFFFFF, bout=1, zero=0, ovf=0.
- **Signed overflow and zero result:**
  - a=0x80000000, b=0x00000001 → diff=0x7FFFFFFF, bout=0, ovf=1.
  - a=0x12345678, b=0x12345677, bin=1 → diff=0, zero=1, bout=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Outputs stay stable and `in_ready`=0.
  - A concurrent `in_valid` with new operands is ignored.
  - Then `out_ready`=1 → next-cycle `in_ready`=1, and the new operands are accepted correctly.
- **Reset mid-operation:** pulse `rst` during the 2nd RUN cycle.
  - `out_valid` never asserts for that operation, and all outputs read 0.
  - `in_ready`=1 the cycle after release, and a following operation (a=10, b=3) gives diff=7.
- **Random regression (WIDTH=8, 32, 64):** 10k random a, b and bin with random `in_valid`/`out_ready` → diff, bout, zero and ovf match the reference model, and every operation is accepted and delivered exactly once.
